// File: rtl/data_sram_responder.sv
// data_sram_responder: slave end of the CPU sram-like data port.
// Word RAM with byte write enables and a registered 1-cycle read path, plus a
// small MMIO window holding LEDs, synchronized switches, a free-running
// counter and a compare register that raises a level timer interrupt.
module data_sram_responder #(
    parameter int unsigned RAM_AW    = 12,
    parameter logic [15:0] MMIO_BASE = 16'hBFAF,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch_in,
    output logic        timer_irq
);

    localparam int unsigned RamWords = 2 ** RAM_AW;

    // MMIO register word offsets (addr[15:2])
    localparam logic [13:0] OffLed     = 14'h0000;
    localparam logic [13:0] OffSwitch  = 14'h0001;
    localparam logic [13:0] OffCount   = 14'h0002;
    localparam logic [13:0] OffCompare = 14'h0003;

    logic [31:0] mem [RamWords];

    logic [31:0]       rdata_q;
    logic [15:0]       led_q;
    logic [7:0]        sw_meta_q;
    logic [7:0]        sw_sync_q;
    logic [31:0]       count_q;
    logic [31:0]       compare_q;
    logic              irq_q;

    logic              is_mmio;
    logic              is_rd;
    logic              is_wr;
    logic [RAM_AW-1:0] ram_idx;
    logic [13:0]       mmio_off;
    logic              ram_we;
    logic              wr_led;
    logic              wr_count;
    logic              wr_compare;
    logic [31:0]       wmask;
    logic [31:0]       mmio_rdata;
    logic [31:0]       rdata_d;
    logic [15:0]       led_wr;
    logic [31:0]       count_wr;
    logic [31:0]       compare_wr;
    logic              unused_addr;

    // Byte offset within a word has no meaning on a word-wide port
    assign unused_addr = ^sram_addr[1:0];

    assign is_mmio  = (sram_addr[31:16] == MMIO_BASE);
    assign is_rd    = sram_en && (sram_wen == 4'b0000);
    assign is_wr    = sram_en && (sram_wen != 4'b0000);
    assign ram_idx  = sram_addr[RAM_AW+1:2];
    assign mmio_off = sram_addr[15:2];

    // resetn folded in here so a write presented during reset never lands
    assign ram_we     = resetn && is_wr && !is_mmio;
    assign wr_led     = is_wr && is_mmio && (mmio_off == OffLed);
    assign wr_count   = is_wr && is_mmio && (mmio_off == OffCount);
    assign wr_compare = is_wr && is_mmio && (mmio_off == OffCompare);

    assign wmask = {{8{sram_wen[3]}}, {8{sram_wen[2]}}, {8{sram_wen[1]}}, {8{sram_wen[0]}}};

    // Byte-merged next values for the read/write registers
    assign led_wr     = (led_q & ~wmask[15:0]) | (sram_wdata[15:0] & wmask[15:0]);
    assign count_wr   = (count_q & ~wmask) | (sram_wdata & wmask);
    assign compare_wr = (compare_q & ~wmask) | (sram_wdata & wmask);

    // RAM byte-lane writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_wen[i]) begin
                    mem[ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // MMIO read mux
    always_comb begin
        mmio_rdata = 32'h0000_0000;
        case (mmio_off)
            OffLed:     mmio_rdata = {16'h0000, led_q};
            OffSwitch:  mmio_rdata = {24'h00_0000, sw_sync_q};
            OffCount:   mmio_rdata = count_q;
            OffCompare: mmio_rdata = compare_q;
            default:    mmio_rdata = 32'h0000_0000;
        endcase
    end

    // Select the read source for this cycle's request
    always_comb begin
        rdata_d = is_mmio ? mmio_rdata : mem[ram_idx];
    end

    // Read data register: updated only by reads, held across writes and idles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'h0000_0000;
        end else if (is_rd) begin
            rdata_q <= rdata_d;
        end
    end

    // Two-flop synchronizer for the asynchronous switch pins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta_q <= 8'h00;
            sw_sync_q <= 8'h00;
        end else begin
            sw_meta_q <= switch_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    // LED register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q <= 16'h0000;
        end else if (wr_led) begin
            led_q <= led_wr;
        end
    end

    // Timer: counter, compare and interrupt; a write beats increment, and a
    // compare write beats a coincident match
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= 32'h0000_0000;
            compare_q <= 32'hFFFF_FFFF;
            irq_q     <= 1'b0;
        end else begin
            if (wr_count) begin
                count_q <= count_wr;
            end else begin
                count_q <= count_q + 32'd1;
            end
            if (wr_compare) begin
                compare_q <= compare_wr;
            end
            if (wr_compare) begin
                irq_q <= 1'b0;
            end else if (count_q == compare_q) begin
                irq_q <= 1'b1;
            end
        end
    end

    assign sram_rdata = rdata_q;
    assign led        = led_q;
    assign timer_irq  = irq_q;

endmodule
